// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared types and constants for the DDR AXI arbiter
package ddr_arb_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } arbState_t;

    localparam logic       ATYPE_WR   = 1'b1;
    localparam logic       ATYPE_RD   = 1'b0;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // AXI size code: log2 of bytes per beat.
    function automatic logic [2:0] axiSize(input int dataW);
        return 3'($clog2(dataW / 8));
    endfunction

    localparam logic [2:0] SIZE_DEFAULT = axiSize(DATA_W_DEFAULT);

endpackage

// File: rtl/ddr_axi_arbiter.sv
// rtl/ddr_axi_arbiter.sv - round-robin arbiter sharing one DDR AXI port between ADC writes and display reads
module ddr_axi_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                  Axi_Clk,
    input  logic                  Axi_Rst,

    input  logic                  wr_req_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [7:0]            wr_len_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  wr_data_valid_i,
    output logic                  wr_grant_o,
    output logic                  wr_data_ready_o,
    output logic                  wr_done_o,

    input  logic                  rd_req_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    input  logic [7:0]            rd_len_i,
    output logic                  rd_grant_o,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_data_valid_o,
    output logic                  rd_done_o,

    output logic [ADDR_W-1:0]     DdrCtrl_AADDR_0,
    output logic [7:0]            DdrCtrl_ALEN_0,
    output logic                  DdrCtrl_ATYPE_0,
    output logic                  DdrCtrl_AVALID_0,
    output logic [1:0]            DdrCtrl_ABURST_0,
    output logic [2:0]            DdrCtrl_ASIZE_0,
    output logic [7:0]            DdrCtrl_AID_0,
    output logic [1:0]            DdrCtrl_ALOCK_0,
    input  logic                  DdrCtrl_AREADY_0,
    output logic [DATA_W-1:0]     DdrCtrl_WDATA_0,
    output logic [DATA_W/8-1:0]   DdrCtrl_WSTRB_0,
    output logic [7:0]            DdrCtrl_WID_0,
    output logic                  DdrCtrl_WLAST_0,
    output logic                  DdrCtrl_WVALID_0,
    input  logic                  DdrCtrl_WREADY_0,
    input  logic                  DdrCtrl_BVALID_0,
    output logic                  DdrCtrl_BREADY_0,
    input  logic [DATA_W-1:0]     DdrCtrl_RDATA_0,
    input  logic                  DdrCtrl_RVALID_0,
    input  logic                  DdrCtrl_RLAST_0,
    output logic                  DdrCtrl_RREADY_0,

    output logic                  err_o
);

    arbState_t         state;
    arbState_t         stateNext;
    logic [ADDR_W-1:0] latchAddr;
    logic [7:0]        latchLen;
    logic              latchType;
    logic [7:0]        beatCnt;
    logic              favorWr;
    logic              wrDoneQ;
    logic              rdDoneQ;
    logic              errQ;
    logic              grantWr;
    logic              grantRd;

    logic inAddr;
    logic inWdata;
    logic inWresp;
    logic inRdata;
    logic lastBeat;
    logic wBeat;
    logic rBeat;

    assign inAddr   = (state == ST_ADDR);
    assign inWdata  = (state == ST_WDATA);
    assign inWresp  = (state == ST_WRESP);
    assign inRdata  = (state == ST_RDATA);
    assign lastBeat = (beatCnt == latchLen);
    assign wBeat    = inWdata & wr_data_valid_i & DdrCtrl_WREADY_0;
    assign rBeat    = inRdata & DdrCtrl_RVALID_0;

    always_comb begin
        stateNext = state;
        grantWr   = 1'b0;
        grantRd   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Grants are suppressed while reset is held so no pulse escapes a reset cycle.
                if (!Axi_Rst) begin
                    if (wr_req_i && (!rd_req_i || favorWr)) begin
                        grantWr = 1'b1;
                    end else if (rd_req_i) begin
                        grantRd = 1'b1;
                    end
                end
                if (grantWr || grantRd) begin
                    stateNext = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (DdrCtrl_AREADY_0) begin
                    stateNext = (latchType == ATYPE_WR) ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                if (wBeat && lastBeat) begin
                    stateNext = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (DdrCtrl_BVALID_0) begin
                    stateNext = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (rBeat && DdrCtrl_RLAST_0) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge Axi_Clk) begin
        if (Axi_Rst) begin
            state     <= ST_IDLE;
            latchAddr <= '0;
            latchLen  <= '0;
            latchType <= ATYPE_RD;
            beatCnt   <= '0;
            favorWr   <= 1'b1;
            wrDoneQ   <= 1'b0;
            rdDoneQ   <= 1'b0;
            errQ      <= 1'b0;
        end else begin
            state   <= stateNext;
            wrDoneQ <= inWresp & DdrCtrl_BVALID_0;
            rdDoneQ <= rBeat & DdrCtrl_RLAST_0;
            if (grantWr || grantRd) begin
                latchAddr <= grantWr ? wr_addr_i : rd_addr_i;
                latchLen  <= grantWr ? wr_len_i : rd_len_i;
                latchType <= grantWr ? ATYPE_WR : ATYPE_RD;
                favorWr   <= grantRd;
                beatCnt   <= '0;
            end else if (wBeat || rBeat) begin
                beatCnt <= beatCnt + 8'd1;
            end
            // Early RLAST, or a beat at/after the expected last one without RLAST, is a protocol error.
            if (rBeat && ((DdrCtrl_RLAST_0 && !lastBeat) ||
                          (!DdrCtrl_RLAST_0 && (beatCnt >= latchLen)))) begin
                errQ <= 1'b1;
            end
        end
    end

    assign wr_grant_o      = grantWr;
    assign rd_grant_o      = grantRd;
    assign wr_done_o       = wrDoneQ;
    assign rd_done_o       = rdDoneQ;
    assign err_o           = errQ;

    assign DdrCtrl_AADDR_0  = latchAddr;
    assign DdrCtrl_ALEN_0   = latchLen;
    assign DdrCtrl_ATYPE_0  = latchType;
    assign DdrCtrl_AVALID_0 = inAddr;
    assign DdrCtrl_ABURST_0 = BURST_INCR;
    assign DdrCtrl_ASIZE_0  = axiSize(DATA_W);
    assign DdrCtrl_AID_0    = '0;
    assign DdrCtrl_ALOCK_0  = '0;

    assign DdrCtrl_WDATA_0  = wr_data_i;
    assign DdrCtrl_WSTRB_0  = '1;
    assign DdrCtrl_WID_0    = '0;
    assign DdrCtrl_WVALID_0 = inWdata & wr_data_valid_i;
    assign DdrCtrl_WLAST_0  = inWdata & lastBeat;
    assign wr_data_ready_o  = wBeat;
    assign DdrCtrl_BREADY_0 = inWresp;

    assign DdrCtrl_RREADY_0 = inRdata;
    assign rd_data_o        = DdrCtrl_RDATA_0;
    assign rd_data_valid_o  = rBeat;

endmodule
